// File: rtl/lifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_ctrl_pkg
// Description : Shared constants for the LIFO push-button command stage:
//               debouncer state encoding and default build parameters.
// Contents    : IDLE/CHK_PRESS/HELD/CHK_REL (2-bit state codes),
//               DEF_DATA_W, DEF_DB_CYCLES, DEF_CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_ctrl_pkg;

    // Debouncer state encoding
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CHK_PRESS = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] CHK_REL   = 2'd3;

    // Default build parameters (10 ms debounce at 100 MHz)
    localparam int DEF_DATA_W    = 6;
    localparam int DEF_DB_CYCLES = 1000000;
    localparam int DEF_CNT_W     = 20;

endpackage : lifo_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, debounce counter and four-state FSM
//               for one raw push button. Raises a one-cycle press pulse
//               when a press has been stable long enough.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               btn   - raw, asynchronous, active-high button
//               press - one-cycle press event (combinational from state)
// Options     : LIFO_CTRL_AUTO_REPEAT_EN - when defined, a held button
//               raises a further press after 4*DB_CYCLES cycles and then
//               every DB_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import lifo_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= btn;
            r_sync <= r_meta;
        end
    end

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state. The counter never passes CNT_MAX: reaching it always
    // coincides with leaving the checking state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_sync) begin
                    w_state_nxt = CHK_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_PRESS: begin
                if (!r_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_sync) begin
                    w_state_nxt = CHK_REL;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_REL: begin
                if (r_sync) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef LIFO_CTRL_AUTO_REPEAT_EN
    // Repeat counter: counts uninterrupted HELD cycles. After the first
    // repeat it is reloaded so that the next one is DB_CYCLES later.
    localparam int               RPT_W      = CNT_W + 2;
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(4 * DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(3 * DB_CYCLES);

    logic [RPT_W-1:0] r_rpt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt <= '0;
        end else if (r_state == HELD && r_sync) begin
            r_rpt <= (r_rpt == RPT_FIRST) ? RPT_RELOAD : r_rpt + RPT_W'(1);
        end else begin
            r_rpt <= '0;
        end
    end
`endif

    // Output: press fires on the last stable sample of the press check
    always_comb begin
        press = (r_state == CHK_PRESS) && r_sync && (r_cnt == CNT_MAX);
`ifdef LIFO_CTRL_AUTO_REPEAT_EN
        if (r_state == HELD && r_sync && r_rpt == RPT_FIRST) begin
            press = 1'b1;
        end
`endif
    end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/lifo_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lifo_btn_ctrl
// Description : Command stage in front of a 4-deep LIFO. Debounces the
//               push/pop buttons, synchronizes the slide switches and turns
//               each accepted press into a single write or read strobe.
//               Operations blocked by full/empty raise a one-cycle err.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               btn_push, btn_pop   - raw active-high buttons
//               sw_data             - raw slide switches
//               empty_flag, full_flag - LIFO status
//               write, read         - one-cycle strobes to the LIFO
//               data_in             - push data, held between writes
//               err                 - one-cycle blocked-operation strobe
// Options     : LIFO_CTRL_AUTO_REPEAT_EN - auto-repeat while a button is
//               held (implemented in btn_debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_btn_ctrl
    import lifo_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_push,
    input  logic              btn_pop,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              empty_flag,
    input  logic              full_flag,
    output logic              write,
    output logic              read,
    output logic [DATA_W-1:0] data_in,
    output logic              err
);

    logic [DATA_W-1:0] r_sw_meta;
    logic [DATA_W-1:0] r_sw_sync;
    logic              w_push_ev;
    logic              w_pop_ev;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_blocked;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_push_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_push),
        .press (w_push_ev)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_pop_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_pop),
        .press (w_pop_ev)
    );

    // Switch synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw_data;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Push and pop are judged independently; both may strobe together
    assign w_push_ok = w_push_ev & ~full_flag;
    assign w_pop_ok  = w_pop_ev  & ~empty_flag;
    assign w_blocked = (w_push_ev & full_flag) | (w_pop_ev & empty_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write   <= 1'b0;
            read    <= 1'b0;
            err     <= 1'b0;
            data_in <= '0;
        end else begin
            write <= w_push_ok;
            read  <= w_pop_ok;
            err   <= w_blocked;
            // Data is captured only with an accepted push
            if (w_push_ok) begin
                data_in <= r_sw_sync;
            end
        end
    end

endmodule : lifo_btn_ctrl
`default_nettype wire
